// File: rtl/reg_skid.sv
// ============================================================================
//  Module   : reg_skid
//  Purpose  : Two-entry valid/ready register slice (main + skid register).
//             Registers both the forward path (valid/data) and the backward
//             path (ready) while sustaining one beat per cycle.
//  Options  : `define REG_SKID_STAT_EN to build the saturating stall counter
//             and its o_stall_cnt port.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_skid #(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RSTN_VALUE = '0,
   parameter int                    STAT_WIDTH = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [DATA_WIDTH-1:0] o_data
`ifdef REG_SKID_STAT_EN
   ,
   output logic [STAT_WIDTH-1:0] o_stall_cnt
`endif
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_BUSY  = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t                state_q;
   logic                  valid_q;
   logic                  ready_q;
   logic [DATA_WIDTH-1:0] main_q;
   logic [DATA_WIDTH-1:0] skid_q;

   logic w_in_fire;
   logic w_out_fire;

   // Handshakes are evaluated against the registered outputs only, so no
   // input ever reaches an output combinationally.
   assign w_in_fire  = i_valid & ready_q;
   assign w_out_fire = valid_q & i_ready;

   assign o_valid = valid_q;
   assign o_ready = ready_q;
   assign o_data  = main_q;

   // Slice state machine: state, registered handshake outputs and both data registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_EMPTY;
         valid_q <= 1'b0;
         ready_q <= 1'b1;
         main_q  <= RSTN_VALUE;
         skid_q  <= RSTN_VALUE;
      end else begin
         case (state_q)
            S_EMPTY: begin
               if (w_in_fire) begin
                  state_q <= S_BUSY;
                  valid_q <= 1'b1;
                  ready_q <= 1'b1;
                  main_q  <= i_data;
               end
            end
            S_BUSY: begin
               if (w_in_fire && w_out_fire) begin
                  // Pass-through: the new beat replaces the departing one.
                  main_q <= i_data;
               end else if (w_in_fire) begin
                  // Consumer stalled: park the new beat behind the main one.
                  state_q <= S_FULL;
                  ready_q <= 1'b0;
                  skid_q  <= i_data;
               end else if (w_out_fire) begin
                  state_q <= S_EMPTY;
                  valid_q <= 1'b0;
               end
            end
            S_FULL: begin
               if (w_out_fire) begin
                  // Skid beat is older than anything upstream, so it goes next.
                  state_q <= S_BUSY;
                  ready_q <= 1'b1;
                  main_q  <= skid_q;
               end
            end
            default: begin
               state_q <= S_EMPTY;
               valid_q <= 1'b0;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

`ifdef REG_SKID_STAT_EN
   logic [STAT_WIDTH-1:0] stall_cnt_q;
   logic                  w_stall;

   assign w_stall     = valid_q & ~i_ready;
   assign o_stall_cnt = stall_cnt_q;

   // Count cycles where a beat is offered but refused; stick at all-ones.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         stall_cnt_q <= '0;
      end else if (w_stall && (stall_cnt_q != {STAT_WIDTH{1'b1}})) begin
         stall_cnt_q <= stall_cnt_q + 1'b1;
      end
   end
`else
   // Counter width is meaningless without the statistics option.
   logic [STAT_WIDTH-1:0] w_unused_stat;
   assign w_unused_stat = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_reg_skid.sv
// ============================================================================
//  Module   : tb_reg_skid
//  Purpose  : Self-checking bench for reg_skid. A two-deep FIFO model
//             predicts the outputs every cycle; directed sequences add
//             hand-computed expectations. Define REG_SKID_STAT_EN to also
//             exercise the stall counter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_reg_skid;

   localparam int          DW    = 32;
   localparam int          SW    = 4;
   localparam logic [31:0] RSTV  = 32'hDEAD_BEEF;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b1;
   logic          i_valid = 1'b0;
   logic [DW-1:0] i_data  = '0;
   logic          i_ready = 1'b1;
   logic          o_ready;
   logic          o_valid;
   logic [DW-1:0] o_data;
`ifdef REG_SKID_STAT_EN
   logic [SW-1:0] o_stall_cnt;
`endif

   int pass_cnt  = 0;
   int total_cnt = 0;
   bit chk_en    = 1'b0;

   reg_skid #(
      .DATA_WIDTH (DW),
      .RSTN_VALUE (RSTV),
      .STAT_WIDTH (SW)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_data      (i_data),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_data      (o_data)
`ifdef REG_SKID_STAT_EN
      ,
      .o_stall_cnt (o_stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference: the slice behaves as a 2-deep FIFO whose outputs reflect the
   // occupancy at the start of the cycle.
   logic [DW-1:0] q[$];
   int            stall_m = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         stall_m = 0;
      end else begin
         automatic bit m_valid = (q.size() != 0);
         automatic bit m_ready = (q.size() < 2);
         if (m_valid && !i_ready && stall_m < (2**SW - 1)) stall_m++;
         if (m_valid && i_ready) void'(q.pop_front());
         if (i_valid && m_ready) q.push_back(i_data);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_valid", {31'd0, o_valid}, {31'd0, q.size() != 0});
         chk("m_ready", {31'd0, o_ready}, {31'd0, q.size() < 2});
         if (q.size() != 0) chk("m_data", o_data, q[0]);
         else if (!rst_n)   chk("m_rst_data", o_data, RSTV);
`ifdef REG_SKID_STAT_EN
         chk("m_stall", {28'd0, o_stall_cnt}, stall_m);
`endif
      end
   end

   task automatic drive(input bit v, input logic [31:0] d, input bit r);
      i_valid = v;
      i_data  = d;
      i_ready = r;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic pend_ready;
      #2 rst_n = 1'b0;
      #1 chk_en = 1'b1;
      chk("rst_valid", {31'd0, o_valid}, 32'd0);
      chk("rst_ready", {31'd0, o_ready}, 32'd1);
      chk("rst_data",  o_data, RSTV);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // 1: streaming at full rate
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k > 1) chk("t1_data", o_data, k - 1);
         chk("t1_ready", {31'd0, o_ready}, 32'd1);
         drive(1'b1, k, 1'b1);
      end
      @(negedge clk);
      chk("t1_last", o_data, 32'h8);
      drive(1'b0, 32'h0, 1'b1);

      // 2: one-beat stall into skid
      @(negedge clk); drive(1'b1, 32'hA, 1'b0);
      @(negedge clk); chk("t2_busy", o_data, 32'hA);
                      drive(1'b1, 32'hB, 1'b0);
      @(negedge clk); chk("t2_full_rdy", {31'd0, o_ready}, 32'd0);
                      chk("t2_full_dat", o_data, 32'hA);
                      drive(1'b0, 32'h0, 1'b1);
      @(negedge clk); chk("t2_skid_out", o_data, 32'hB);
                      chk("t2_rdy_back", {31'd0, o_ready}, 32'd1);
      @(negedge clk); chk("t2_empty", {31'd0, o_valid}, 32'd0);

      // 3: backpressure holds off the third beat
      drive(1'b1, 32'hC, 1'b1);
      @(negedge clk); chk("t3_c", o_data, 32'hC);
                      drive(1'b1, 32'hD, 1'b0);
      @(negedge clk); chk("t3_full", {31'd0, o_ready}, 32'd0);
                      drive(1'b1, 32'hE, 1'b0);
      @(negedge clk); chk("t3_hold_c", o_data, 32'hC);
                      drive(1'b1, 32'hE, 1'b1);
      @(negedge clk); chk("t3_d", o_data, 32'hD);
      @(negedge clk); chk("t3_e", o_data, 32'hE);
                      drive(1'b0, 32'h0, 1'b1);
      @(negedge clk); chk("t3_done", {31'd0, o_valid}, 32'd0);

      // 4: asynchronous reset while FULL
      drive(1'b1, 32'h11, 1'b0);
      @(negedge clk); drive(1'b1, 32'h22, 1'b0);
      @(negedge clk); drive(1'b0, 32'h0, 1'b0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk("t4_valid", {31'd0, o_valid}, 32'd0);
         chk("t4_ready", {31'd0, o_ready}, 32'd1);
         chk("t4_data",  o_data, RSTV);
      @(negedge clk); rst_n = 1'b1; drive(1'b0, 32'h0, 1'b1);
      @(negedge clk); chk("t4_no_stale", {31'd0, o_valid}, 32'd0);
                      drive(1'b1, 32'h33, 1'b1);
      @(negedge clk); chk("t4_first", o_data, 32'h33);
                      drive(1'b0, 32'h0, 1'b1);
      @(negedge clk);

      // 5: random traffic; producer holds a beat until it is taken
      pend_ready = o_ready;
      for (int i = 0; i < 10000; i++) begin
         @(negedge clk);
         if (!(i_valid && !pend_ready)) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i_data  = $urandom;
         end
         i_ready    = ($urandom_range(0, 2) != 0);
         pend_ready = o_ready;
      end
      @(negedge clk); drive(1'b0, 32'h0, 1'b1);
      repeat (3) @(negedge clk);
      chk("t5_drained", {31'd0, o_valid}, 32'd0);

`ifdef REG_SKID_STAT_EN
      // 6: stall counter saturation and reset
      do_reset();
      drive(1'b1, 32'h55, 1'b0);
      @(negedge clk); drive(1'b0, 32'h0, 1'b0);
      repeat (20) @(negedge clk);
      chk("t6_sat", {28'd0, o_stall_cnt}, 32'hF);
      repeat (3) @(negedge clk);
      chk("t6_hold", {28'd0, o_stall_cnt}, 32'hF);
      do_reset();
      #1 chk("t6_rst", {28'd0, o_stall_cnt}, 32'h0);
`endif

      @(negedge clk);
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

`default_nettype wire
